// File: rtl/toy_intc.sv
// Toy interrupt controller: masks sticky device interrupts, grants the lowest index to the CPU,
// pulses an ack back to the device and waits for EOI. Define TOY_INTC_EDGE_EN for edge capture.
module toy_intc #(
  parameter int unsigned N_SRC = 2,
  parameter int unsigned ID_W  = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] dev_intr,
  output logic [N_SRC-1:0] dev_ack,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  output logic [N_SRC-1:0] mask,
  output logic             cpu_intr,
  output logic [ID_W-1:0]  cpu_id,
  input  logic             cpu_ack,
  input  logic             cpu_eoi,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ACK     = 2'd2,
    SERVICE = 2'd3
  } state_t;

  state_t           state;
  logic [N_SRC-1:0] src;
  logic [N_SRC-1:0] elig;
  logic [ID_W-1:0]  win_id;
  logic [N_SRC-1:0] id_onehot;

  // Fixed priority: lowest set index wins.
  function automatic logic [ID_W-1:0] lowest_idx(input logic [N_SRC-1:0] v);
    lowest_idx = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = ID_W'(i);
    end
  endfunction

`ifdef TOY_INTC_EDGE_EN
  logic [N_SRC-1:0] prev;
  logic [N_SRC-1:0] pending;

  // Capture rising edges; a new edge in the ACK cycle outlives the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev    <= '0;
      pending <= '0;
    end else begin
      prev    <= dev_intr;
      pending <= (pending & ~dev_ack) | (dev_intr & ~prev);
    end
  end

  assign src = pending;
`else
  assign src = dev_intr;
`endif

  assign elig      = src & ~mask;
  assign win_id    = lowest_idx(elig);
  assign id_onehot = N_SRC'(1) << cpu_id;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask <= '0;
    end else if (mask_we) begin
      mask <= mask_wdata;
    end
  end

  // Request/ack/service handshake; cpu_id stays frozen until the next arbitration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cpu_intr <= 1'b0;
      cpu_id   <= '0;
      dev_ack  <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (elig != '0) begin
            state    <= REQ;
            cpu_id   <= win_id;
            cpu_intr <= 1'b1;
            busy     <= 1'b1;
          end
        end
        REQ: begin
          if (cpu_ack) begin
            state    <= ACK;
            cpu_intr <= 1'b0;
            dev_ack  <= id_onehot;
          end
        end
        ACK: begin
          state   <= SERVICE;
          dev_ack <= '0;
        end
        SERVICE: begin
          if (cpu_eoi) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          cpu_intr <= 1'b0;
          dev_ack  <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_toy_intc.sv
// Bench for toy_intc: directed scenarios plus randomized traffic against a transaction-level model.
module tb_toy_intc;
  localparam int unsigned N    = 4;
  localparam int unsigned IDW  = 2;
`ifdef TOY_INTC_EDGE_EN
  localparam int unsigned LAT  = 2;
`else
  localparam int unsigned LAT  = 1;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   dev_intr = '0;
  logic [N-1:0]   dev_ack;
  logic           mask_we = 1'b0;
  logic [N-1:0]   mask_wdata = '0;
  logic [N-1:0]   mask;
  logic           cpu_intr;
  logic [IDW-1:0] cpu_id;
  logic           cpu_ack = 1'b0;
  logic           cpu_eoi = 1'b0;
  logic           busy;

  int checks = 0;
  int errors = 0;

  // Device-side line state and an auto-clear toggle (device drops intr on seeing its ack).
  logic [N-1:0] dev = '0;
  bit           auto_clr = 1'b1;

  // Reference model: observable outputs plus edge-capture bookkeeping.
  logic           m_intr, m_busy;
  logic [IDW-1:0] m_id;
  logic [N-1:0]   m_ack, m_mask, m_pend, m_prev;

  toy_intc #(.N_SRC(N), .ID_W(IDW)) dut (
    .clk(clk), .rst(rst), .dev_intr(dev_intr), .dev_ack(dev_ack),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .mask(mask),
    .cpu_intr(cpu_intr), .cpu_id(cpu_id), .cpu_ack(cpu_ack), .cpu_eoi(cpu_eoi), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reset_model();
    m_intr = 1'b0; m_busy = 1'b0; m_id = '0;
    m_ack = '0; m_mask = '0; m_pend = '0; m_prev = '0;
  endtask

  // One clock: drive inputs, predict the post-edge outputs, advance to just after the edge.
  task automatic tick(input logic mwe, input logic [N-1:0] mwd, input logic ack, input logic eoi);
    logic [N-1:0] src, elig, n_ack, n_mask, n_pend;
    logic [IDW-1:0] n_id;
    logic n_intr, n_busy, found;
    if (auto_clr) dev = dev & ~m_ack;
    dev_intr = dev; mask_we = mwe; mask_wdata = mwd; cpu_ack = ack; cpu_eoi = eoi;
`ifdef TOY_INTC_EDGE_EN
    src = m_pend;
`else
    src = dev;
`endif
    elig = src & ~m_mask;
    n_intr = m_intr; n_busy = m_busy; n_id = m_id; n_ack = m_ack;
    if (!m_busy) begin
      found = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
        if (elig[i] && !found) begin
          n_id = IDW'(i);
          found = 1'b1;
        end
      end
      if (found) begin
        n_intr = 1'b1;
        n_busy = 1'b1;
      end
    end else if (m_intr) begin
      if (ack) begin
        n_intr = 1'b0;
        n_ack = '0;
        n_ack[m_id] = 1'b1;
      end
    end else if (m_ack != '0) begin
      n_ack = '0;
    end else if (eoi) begin
      n_busy = 1'b0;
    end
    n_mask = mwe ? mwd : m_mask;
    n_pend = (m_pend & ~m_ack) | (dev & ~m_prev);
    @(posedge clk);
    #1;
    m_intr = n_intr; m_busy = n_busy; m_id = n_id; m_ack = n_ack;
    m_mask = n_mask; m_pend = n_pend; m_prev = dev;
    mask_we = 1'b0; cpu_ack = 1'b0; cpu_eoi = 1'b0;
  endtask

  task automatic idle_tick();
    tick(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({cpu_intr, cpu_id, dev_ack, mask, busy} !== '0) begin
      errors++;
      $display("FAIL reset_async: outs=%h exp 0", {cpu_intr, cpu_id, dev_ack, mask, busy});
    end
    reset_model();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle_tick();
    checks++;
    if ({cpu_intr, cpu_id, dev_ack, mask, busy} !== '0) begin
      errors++;
      $display("FAIL reset_idle: outs=%h exp 0", {cpu_intr, cpu_id, dev_ack, mask, busy});
    end
  endtask

  task automatic test_single();
    dev = 4'b0001;
    repeat (LAT) idle_tick();
    checks++;
    if ({cpu_intr, cpu_id, busy, dev_ack} !== {1'b1, 2'd0, 1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL single_req: intr=%b id=%0d busy=%b ack=%b exp 1/0/1/0000", cpu_intr, cpu_id, busy, dev_ack);
    end
    tick(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if ({cpu_intr, dev_ack} !== {1'b0, 4'b0001}) begin
      errors++;
      $display("FAIL single_ack: intr=%b dev_ack=%b exp 0/0001", cpu_intr, dev_ack);
    end
    idle_tick();
    checks++;
    if ({dev_ack, busy} !== {4'b0000, 1'b1}) begin
      errors++;
      $display("FAIL single_service: dev_ack=%b busy=%b exp 0000/1", dev_ack, busy);
    end
    tick(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if ({cpu_intr, busy} !== 2'b00) begin
      errors++;
      $display("FAIL single_eoi: intr=%b busy=%b exp 0/0", cpu_intr, busy);
    end
  endtask

  task automatic test_priority();
    dev = 4'b0011;
    repeat (LAT) idle_tick();
    checks++;
    if ({cpu_intr, cpu_id} !== {1'b1, 2'd0}) begin
      errors++;
      $display("FAIL prio_first: intr=%b id=%0d exp 1/0", cpu_intr, cpu_id);
    end
    tick(1'b0, '0, 1'b1, 1'b0);
    idle_tick();
    tick(1'b0, '0, 1'b0, 1'b1);
    idle_tick();
    checks++;
    if ({cpu_intr, cpu_id} !== {1'b1, 2'd1}) begin
      errors++;
      $display("FAIL prio_second: intr=%b id=%0d exp 1/1", cpu_intr, cpu_id);
    end
    tick(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (dev_ack !== 4'b0010) begin
      errors++;
      $display("FAIL prio_ack: dev_ack=%b exp 0010", dev_ack);
    end
    idle_tick();
    tick(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_mask();
    tick(1'b1, 4'b0001, 1'b0, 1'b0);
    dev = 4'b0001;
    repeat (LAT + 2) idle_tick();
    checks++;
    if ({cpu_intr, busy, mask} !== {1'b0, 1'b0, 4'b0001}) begin
      errors++;
      $display("FAIL mask_hold: intr=%b busy=%b mask=%b exp 0/0/0001", cpu_intr, busy, mask);
    end
    tick(1'b1, 4'b0000, 1'b0, 1'b0);
    checks++;
    if ({cpu_intr, mask} !== {1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL mask_old_used: intr=%b mask=%b exp 0/0000", cpu_intr, mask);
    end
    idle_tick();
    checks++;
    if ({cpu_intr, cpu_id} !== {1'b1, 2'd0}) begin
      errors++;
      $display("FAIL mask_release: intr=%b id=%0d exp 1/0", cpu_intr, cpu_id);
    end
    tick(1'b0, '0, 1'b1, 1'b0);
    idle_tick();
    tick(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_ack_eoi();
    dev = 4'b0100;
    repeat (LAT) idle_tick();
    tick(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if ({cpu_intr, cpu_id, busy} !== {1'b1, 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL eoi_in_req: intr=%b id=%0d busy=%b exp 1/2/1", cpu_intr, cpu_id, busy);
    end
    tick(1'b0, '0, 1'b1, 1'b1);
    checks++;
    if ({cpu_intr, dev_ack} !== {1'b0, 4'b0100}) begin
      errors++;
      $display("FAIL ack_eoi_same: intr=%b dev_ack=%b exp 0/0100", cpu_intr, dev_ack);
    end
    repeat (2) idle_tick();
    checks++;
    if ({busy, dev_ack} !== {1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL service_wait: busy=%b dev_ack=%b exp 1/0000", busy, dev_ack);
    end
    tick(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL service_eoi: busy=%b exp 0", busy);
    end
  endtask

  task automatic test_reset_mid_ack();
    bit seen;
    auto_clr = 1'b0;
    dev = 4'b0010;
    repeat (LAT) idle_tick();
    tick(1'b0, '0, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({dev_ack, cpu_intr, busy} !== {4'b0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_ack: dev_ack=%b intr=%b busy=%b exp 0000/0/0", dev_ack, cpu_intr, busy);
    end
    reset_model();
    #1 rst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 3 && !seen; k++) begin
      idle_tick();
      seen = (cpu_intr === 1'b1);
    end
    checks++;
    if (!seen || cpu_id !== 2'd1) begin
      errors++;
      $display("FAIL reset_rerequest: intr=%b id=%0d exp 1/1 within 3 cycles", cpu_intr, cpu_id);
    end
    auto_clr = 1'b1;
    tick(1'b0, '0, 1'b1, 1'b0);
    idle_tick();
    tick(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic mwe, ack, eoi;
    logic [N-1:0] mwd;
    for (int c = 0; c < 3000; c++) begin
      r = $urandom;
      if (r[3:0] == 4'd0) dev = dev | N'($urandom);
`ifdef TOY_INTC_EDGE_EN
      if (r[7:4] == 4'd0) dev = dev & N'($urandom);
`endif
      mwe = (r[11:8] == 4'd0);
      mwd = N'($urandom & $urandom);
      ack = r[12];
      eoi = (r[15:14] == 2'd0);
      tick(mwe, mwd, ack, eoi);
      checks++;
      if ({cpu_intr, cpu_id, dev_ack, mask, busy} !== {m_intr, m_id, m_ack, m_mask, m_busy}) begin
        errors++;
        $display("FAIL random_c%0d: intr/id/ack/mask/busy=%b/%0d/%b/%b/%b exp %b/%0d/%b/%b/%b", c,
                 cpu_intr, cpu_id, dev_ack, mask, busy, m_intr, m_id, m_ack, m_mask, m_busy);
      end
    end
    // Drain to idle with everything unmasked.
    tick(1'b1, '0, 1'b0, 1'b0);
    for (int k = 0; k < 40 && (m_busy || cpu_intr); k++) tick(1'b0, '0, m_intr, 1'b1);
    dev = '0;
    repeat (4) tick(1'b0, '0, m_intr, 1'b1);
  endtask

`ifdef TOY_INTC_EDGE_EN
  task automatic test_edge();
    auto_clr = 1'b0;
    dev = 4'b0001;
    repeat (2) idle_tick();
    checks++;
    if ({cpu_intr, cpu_id} !== {1'b1, 2'd0}) begin
      errors++;
      $display("FAIL edge_first: intr=%b id=%0d exp 1/0", cpu_intr, cpu_id);
    end
    tick(1'b0, '0, 1'b1, 1'b0);
    idle_tick();
    tick(1'b0, '0, 1'b0, 1'b1);
    repeat (4) idle_tick();
    checks++;
    if ({cpu_intr, busy} !== 2'b00) begin
      errors++;
      $display("FAIL edge_held_level: intr=%b busy=%b exp 0/0", cpu_intr, busy);
    end
    dev = 4'b0000;
    idle_tick();
    dev = 4'b0001;
    repeat (2) idle_tick();
    checks++;
    if ({cpu_intr, cpu_id} !== {1'b1, 2'd0}) begin
      errors++;
      $display("FAIL edge_retoggle: intr=%b id=%0d exp 1/0", cpu_intr, cpu_id);
    end
    dev = 4'b0000;
    tick(1'b0, '0, 1'b1, 1'b0);
    dev = 4'b0001;
    idle_tick();
    tick(1'b0, '0, 1'b0, 1'b1);
    idle_tick();
    checks++;
    if ({cpu_intr, cpu_id} !== {1'b1, 2'd0}) begin
      errors++;
      $display("FAIL edge_set_wins: intr=%b id=%0d exp 1/0", cpu_intr, cpu_id);
    end
    tick(1'b0, '0, 1'b1, 1'b0);
    idle_tick();
    tick(1'b0, '0, 1'b0, 1'b1);
    auto_clr = 1'b1;
  endtask
`endif

  initial begin
    reset_model();
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_ack_eoi();
    test_reset_mid_ack();
`ifdef TOY_INTC_EDGE_EN
    test_edge();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
